td4x_core: RTL and testbench

Parametrised successor to the 4-bit TD4-style CPU core: same accumulator/B-register/out-port architecture and instruction encoding, generalised to DATA_W-bit data and ADDR_W-bit program counter. Adds an instruction-fetch valid handshake (wait states), an output strobe, a zero flag and a retire pulse. Sits between an external program ROM or memory and the chip's I/O pins, replacing the fixed 4-bit core.

---
 rtl/td4x_pkg.sv | 23 ++
 rtl/td4x_decode.sv | 54 +++++
 rtl/td4x_core.sv | 124 ++++++++++++
 tb/tb_td4x_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/td4x_pkg.sv
// Shared opcodes, FSM states and ALU source selects for the td4x core and decoder.
// Opcodes 1000/1010/1100/1101 change meaning when TD4X_EXT_ISA_EN is defined.
package td4x_pkg;
  localparam logic [3:0] OP_ADD_A   = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B = 4'b0001;
  localparam logic [3:0] OP_IN_A    = 4'b0010;
  localparam logic [3:0] OP_MOV_A   = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A = 4'b0100;
  localparam logic [3:0] OP_ADD_B   = 4'b0101;
  localparam logic [3:0] OP_IN_B    = 4'b0110;
  localparam logic [3:0] OP_MOV_B   = 4'b0111;
  localparam logic [3:0] OP_HLT     = 4'b1000;
  localparam logic [3:0] OP_OUT_B   = 4'b1001;
  localparam logic [3:0] OP_OUT_A   = 4'b1010;
  localparam logic [3:0] OP_OUT_IM  = 4'b1011;
  localparam logic [3:0] OP_JZ      = 4'b1100;
  localparam logic [3:0] OP_JNZ     = 4'b1101;
  localparam logic [3:0] OP_JNC     = 4'b1110;
  localparam logic [3:0] OP_JMP     = 4'b1111;

  typedef enum logic {ST_RUN, ST_HALT} state_e;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_e;
endpackage

// File: rtl/td4x_decode.sv
// Combinational decoder: opcode and flags to ALU source, load enables, jump and halt.
// Alias opcodes follow the extended ISA when TD4X_EXT_ISA_EN is defined.
module td4x_decode
  import td4x_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic       i_carry,
`ifdef TD4X_EXT_ISA_EN
  input  logic       i_zero,
`endif
  output src_e       o_src,
  output logic       o_ld_a,
  output logic       o_ld_b,
  output logic       o_ld_out,
  output logic       o_jump,
  output logic       o_halt
);

  always_comb begin
    o_src    = SRC_ZERO;
    o_ld_a   = 1'b0;
    o_ld_b   = 1'b0;
    o_ld_out = 1'b0;
    o_jump   = 1'b0;
    o_halt   = 1'b0;
    case (i_op)
      OP_ADD_A:   begin o_src = SRC_A;  o_ld_a = 1'b1; end
      OP_MOV_A_B: begin o_src = SRC_B;  o_ld_a = 1'b1; end
      OP_IN_A:    begin o_src = SRC_IN; o_ld_a = 1'b1; end
      OP_MOV_A:   o_ld_a = 1'b1;
      OP_MOV_B_A: begin o_src = SRC_A;  o_ld_b = 1'b1; end
      OP_ADD_B:   begin o_src = SRC_B;  o_ld_b = 1'b1; end
      OP_IN_B:    begin o_src = SRC_IN; o_ld_b = 1'b1; end
      OP_MOV_B:   o_ld_b = 1'b1;
      OP_OUT_B:   begin o_src = SRC_B;  o_ld_out = 1'b1; end
      OP_OUT_IM:  o_ld_out = 1'b1;
      OP_JNC:     begin o_src = SRC_A;  o_jump = ~i_carry; end
      OP_JMP:     begin o_src = SRC_A;  o_jump = 1'b1; end
`ifdef TD4X_EXT_ISA_EN
      OP_HLT:     o_halt = 1'b1;
      OP_OUT_A:   begin o_src = SRC_A;  o_ld_out = 1'b1; end
      OP_JZ:      begin o_src = SRC_A;  o_jump = i_zero; end
      OP_JNZ:     begin o_src = SRC_A;  o_jump = ~i_zero; end
`else
      OP_HLT:     begin o_src = SRC_B;  o_ld_out = 1'b1; end
      OP_OUT_A:   o_ld_out = 1'b1;
      OP_JZ:      begin o_src = SRC_A;  o_jump = ~i_carry; end
      OP_JNZ:     begin o_src = SRC_A;  o_jump = 1'b1; end
`endif
      default:    o_src = SRC_ZERO;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// Parametrised TD4-style accumulator core with fetch-valid wait states and output strobe.
// Defining TD4X_EXT_ISA_EN enables the zero flag, JZ/JNZ, OUT A and HLT with the HALT state.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   pc,
  input  logic [DATA_W+3:0]   instr,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_stb,
  output logic                retire,
  output logic                carry,
  output logic                halted
);

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_carry;
  logic              r_out_stb;
  logic              r_retire;
  state_e            r_state;
  state_e            w_state_nxt;

  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_im;
  src_e              w_src;
  logic [DATA_W-1:0] w_src_val;
  logic [DATA_W:0]   w_sum;
  logic              w_ld_a, w_ld_b, w_ld_out, w_jump, w_halt, w_exec;

  assign w_op   = instr[DATA_W+3:DATA_W];
  assign w_im   = instr[DATA_W-1:0];
  assign w_exec = (r_state == ST_RUN) && instr_valid;

`ifdef TD4X_EXT_ISA_EN
  logic r_zero;
`endif

  td4x_decode u_decode (
    .i_op     (w_op),
    .i_carry  (r_carry),
`ifdef TD4X_EXT_ISA_EN
    .i_zero   (r_zero),
`endif
    .o_src    (w_src),
    .o_ld_a   (w_ld_a),
    .o_ld_b   (w_ld_b),
    .o_ld_out (w_ld_out),
    .o_jump   (w_jump),
    .o_halt   (w_halt)
  );

  always_comb begin
    w_src_val = '0;
    case (w_src)
      SRC_A:   w_src_val = r_a;
      SRC_B:   w_src_val = r_b;
      SRC_IN:  w_src_val = in_data;
      default: w_src_val = '0;
    endcase
  end

  assign w_sum = {1'b0, w_src_val} + {1'b0, w_im};

  always_comb begin
    w_state_nxt = r_state;
    if (w_exec && w_halt) w_state_nxt = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // HLT retires without advancing pc, so pc stays on the HLT address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_out     <= '0;
      r_carry   <= 1'b0;
      r_out_stb <= 1'b0;
      r_retire  <= 1'b0;
`ifdef TD4X_EXT_ISA_EN
      r_zero    <= 1'b0;
`endif
    end else begin
      r_retire  <= w_exec;
      r_out_stb <= w_exec && w_ld_out;
      if (w_exec) begin
        r_carry <= w_sum[DATA_W];
`ifdef TD4X_EXT_ISA_EN
        r_zero  <= (w_sum[DATA_W-1:0] == '0);
`endif
        if (w_ld_a)   r_a   <= w_sum[DATA_W-1:0];
        if (w_ld_b)   r_b   <= w_sum[DATA_W-1:0];
        if (w_ld_out) r_out <= w_sum[DATA_W-1:0];
        if (w_jump)       r_pc <= ADDR_W'(w_im);
        else if (!w_halt) r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  assign pc       = r_pc;
  assign out_data = r_out;
  assign out_stb  = r_out_stb;
  assign retire   = r_retire;
  assign carry    = r_carry;
`ifdef TD4X_EXT_ISA_EN
  assign halted   = (r_state == ST_HALT);
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_td4x_core.sv
// Self-checking bench for td4x_core: directed program steps plus random instructions
// checked against an instruction-level reference model (build with TD4X_EXT_ISA_EN for ext ISA).
module tb_td4x_core;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int IW = DW + 4;
`ifdef TD4X_EXT_ISA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] out_data;
  logic          out_stb, retire, carry, halted;

  td4x_core #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .in_data(in_data), .out_data(out_data), .out_stb(out_stb), .retire(retire),
    .carry(carry), .halted(halted)
  );

  logic        reset_w = 1'b1;
  logic [11:0] instr_w = '0;
  logic        valid_w = 1'b0;
  logic [7:0]  in_w = '0;
  logic [5:0]  pc_w;
  logic [7:0]  out_w;
  logic        stb_w, ret_w, carry_w, halt_w;

  td4x_core #(.DATA_W(8), .ADDR_W(6)) u_dut_w (
    .clk(clk), .reset(reset_w), .pc(pc_w), .instr(instr_w), .instr_valid(valid_w),
    .in_data(in_w), .out_data(out_w), .out_stb(stb_w), .retire(ret_w),
    .carry(carry_w), .halted(halt_w)
  );

  int checks = 0;
  int failures = 0;

  int m_a, m_b, m_out, m_pc;
  bit m_c, m_z, m_stb, m_ret, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0;
    m_c = 0; m_z = 0; m_stb = 0; m_ret = 0; m_halt = 0;
  endtask

  // Instruction semantics: dst 1=A, 2=B, 3=out port.
  task automatic model_exec(input logic [3:0] op, input int im, input int din);
    int src, dst, sum, r;
    bit jmp, hlt;
    src = 0; dst = 0; jmp = 0; hlt = 0;
    case (op)
      4'h0: begin src = m_a; dst = 1; end
      4'h1: begin src = m_b; dst = 1; end
      4'h2: begin src = din; dst = 1; end
      4'h3: dst = 1;
      4'h4: begin src = m_a; dst = 2; end
      4'h5: begin src = m_b; dst = 2; end
      4'h6: begin src = din; dst = 2; end
      4'h7: dst = 2;
      4'h8: if (EXT) hlt = 1; else begin src = m_b; dst = 3; end
      4'h9: begin src = m_b; dst = 3; end
      4'hA: begin src = EXT ? m_a : 0; dst = 3; end
      4'hB: dst = 3;
      4'hC: begin src = m_a; jmp = EXT ? m_z : !m_c; end
      4'hD: begin src = m_a; jmp = EXT ? !m_z : 1'b1; end
      4'hE: begin src = m_a; jmp = !m_c; end
      default: begin src = m_a; jmp = 1; end
    endcase
    sum = src + im;
    r = sum % (1 << DW);
    if (dst == 1) m_a = r;
    if (dst == 2) m_b = r;
    if (dst == 3) m_out = r;
    m_c = (sum >= (1 << DW));
    m_z = (r == 0);
    if (jmp) m_pc = im % (1 << AW);
    else if (!hlt) m_pc = (m_pc + 1) % (1 << AW);
    m_stb = (dst == 3);
    m_ret = 1;
    if (hlt) m_halt = 1;
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [3:0] op,
                       input logic [DW-1:0] im, input logic [DW-1:0] din);
    @(negedge clk);
    reset = rst; instr_valid = v; instr = {op, im}; in_data = din;
    @(posedge clk);
    if (rst) model_reset();
    else if (v && !m_halt) model_exec(op, int'(im), int'(din));
    else begin m_stb = 0; m_ret = 0; end
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("out_data", 32'(out_data), 32'(m_out));
    chk("out_stb", 32'(out_stb), 32'(m_stb));
    chk("retire", 32'(retire), 32'(m_ret));
    chk("carry", 32'(carry), 32'(m_c));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic cycle_w(input bit rst, input logic [3:0] op, input logic [7:0] im,
                         input logic [7:0] din);
    @(negedge clk);
    reset_w = rst; valid_w = 1'b1; instr_w = {op, im}; in_w = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    // Reset state
    cycle(1, 1, 4'hB, 4'd9, 4'd0);
    chk("rst_pc", 32'(pc), 32'd0);

    // Defaults program: MOV A,3; ADD A,14; JNC 0; OUT B
    cycle(0, 1, 4'h3, 4'd3, 4'd0);
    cycle(0, 1, 4'h0, 4'd14, 4'd0);
    chk("add_carry", 32'(carry), 32'd1);
    cycle(0, 1, 4'hE, 4'd0, 4'd0);
    chk("jnc_not_taken_pc", 32'(pc), 32'd3);
    cycle(0, 1, 4'h9, 4'd0, 4'd0);
    chk("out_b_data", 32'(out_data), 32'd0);
    chk("out_b_stb", 32'(out_stb), 32'd1);
    cycle(0, 1, 4'h4, 4'd0, 4'd0);
    chk("stb_one_cycle", 32'(out_stb), 32'd0);
    cycle(0, 1, 4'h9, 4'd0, 4'd0);
    chk("a_value", 32'(out_data), 32'd1);

    // Wait states at pc=2
    cycle(1, 0, 4'h0, 4'd0, 4'd0);
    cycle(0, 1, 4'h3, 4'd3, 4'd0);
    cycle(0, 1, 4'h0, 4'd14, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 4'($urandom), 4'($urandom), 4'($urandom));
      chk("wait_pc", 32'(pc), 32'd2);
      chk("wait_retire", 32'(retire), 32'd0);
      chk("wait_carry", 32'(carry), 32'd1);
    end
    cycle(0, 1, 4'hE, 4'd0, 4'd0);
    chk("after_wait_pc", 32'(pc), 32'd3);
    chk("after_wait_retire", 32'(retire), 32'd1);

    // PC wrap with sixteen ADD A,1
    cycle(1, 0, 4'h0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 4'h0, 4'd1, 4'd0);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_carry", 32'(carry), 32'd1);

    // Reset mid-run during OUT im=9
    cycle(0, 1, 4'h3, 4'd5, 4'd0);
    cycle(1, 1, 4'hB, 4'd9, 4'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_stb", 32'(out_stb), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);

`ifdef TD4X_EXT_ISA_EN
    // MOV A,0; JZ 5; HLT at 5
    cycle(0, 1, 4'h3, 4'd0, 4'd0);
    cycle(0, 1, 4'hC, 4'd5, 4'd0);
    chk("jz_taken_pc", 32'(pc), 32'd5);
    cycle(0, 1, 4'h8, 4'd0, 4'd0);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_retire", 32'(retire), 32'd1);
    chk("hlt_pc", 32'(pc), 32'd5);
    cycle(0, 1, 4'h0, 4'd1, 4'd0);
    chk("halt_pc_frozen", 32'(pc), 32'd5);
    chk("halt_no_retire", 32'(retire), 32'd0);
    cycle(1, 1, 4'h8, 4'd0, 4'd0);
    chk("halt_reset_pc", 32'(pc), 32'd0);
    chk("halt_reset_halted", 32'(halted), 32'd0);
`endif

    // Random instructions, wait states and occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Wide instance: DATA_W=8, ADDR_W=6
    cycle_w(1, 4'h0, 8'h00, 8'h00);
    chk("w_rst_pc", 32'(pc_w), 32'd0);
    cycle_w(0, 4'h2, 8'h00, 8'hF0);
    cycle_w(0, 4'h0, 8'h20, 8'h00);
    chk("w_add_carry", 32'(carry_w), 32'd1);
    cycle_w(0, 4'hF, 8'hFF, 8'h00);
    chk("w_jmp_pc", 32'(pc_w), 32'h3F);
    chk("w_jmp_carry", 32'(carry_w), 32'd1);
    cycle_w(0, 4'h4, 8'h00, 8'h00);
    chk("w_wrap_pc", 32'(pc_w), 32'd0);
    cycle_w(0, 4'h9, 8'h00, 8'h00);
    chk("w_a_value", 32'(out_w), 32'h10);
    chk("w_out_stb", 32'(stb_w), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
